// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, wait-counter
// sizing and the legal latency range.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    // Legal latencies must fit the wait counter, which holds LATENCY-1.
    function automatic bit latency_ok(input int lat);
        return (lat >= 1) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: one write port and one registered read port,
// both enable-gated; contents are never reset.
module dmem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // The read register holds its value while rd_en is low, so a captured
    // load stays stable for as long as the response is stalled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one outstanding
// load/store, fixed LATENCY from acceptance to response, valid/ready on both sides.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int WIDX_W = ADDR_W - 2;

    if (!latency_ok(LATENCY)) begin : g_latency_check
        $error("dmem_responder: LATENCY must be within 1..%0d", LAT_MAX);
    end

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic              load_ok_q;

    logic              commit;
    logic              addr_err;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] arr_rdata;

    // Out-of-range word indices are errors rather than wrapping onto low words.
    assign commit   = (state == ST_WAIT) && (cnt == '0);
    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      (addr_q[ADDR_W-1:2] >= WIDX_W'(DEPTH_WORDS));
    assign wr_en    = commit && write_q && !addr_err;
    assign rd_en    = commit && !write_q && !addr_err;

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk_i),
        .wr_en   (wr_en),
        .wr_idx  (addr_q[IDX_W+1:2]),
        .wr_data (wdata_q),
        .rd_en   (rd_en),
        .rd_idx  (addr_q[IDX_W+1:2]),
        .rd_data (arr_rdata)
    );

    // Ready is registered, so it is low during reset and rises on the first
    // edge after release; it returns high on the edge that completes a response.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid_i && ready_q) begin
                        write_q <= req_write_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt     <= CNT_W'(LATENCY - 1);
                        ready_q <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        valid_q   <= 1'b1;
                        err_q     <= addr_err;
                        load_ok_q <= rd_en;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        valid_q   <= 1'b0;
                        err_q     <= 1'b0;
                        load_ok_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data only passes through for a successful load; stores and errors read as zero.
    assign rsp_rdata_o = load_ok_q ? arr_rdata : '0;
    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: four instances built with LATENCY 2, 4, 1 and 15.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [4];
    logic        req_ready [4];
    logic        req_write [4];
    logic [31:0] req_addr  [4];
    logic [31:0] req_wdata [4];
    logic        rsp_valid [4];
    logic        rsp_ready [4];
    logic [31:0] rsp_rdata [4];
    logic        rsp_err   [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 15;
        dmem_responder #(
            .DATA_W      (32),
            .ADDR_W      (32),
            .DEPTH_WORDS (128),
            .LATENCY     (LAT)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_write_i (req_write[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .rsp_err_o   (rsp_err[g])
        );
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 4;
            2:       return 1;
            default: return 15;
        endcase
    endfunction

    // Presents a request, waits for acceptance, then counts edges until the response;
    // returns just after the edge that consumes the response (rsp_ready must be high).
    task automatic transact(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat,
                            output logic [31:0] rdata, output logic err);
        int waited = 0;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        while (!req_ready[d] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_write[d] = 1'bx;
        req_addr[d]  = 'x;
        req_wdata[d] = 'x;
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (waited >= 50) lat = 99;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
    endtask

    task automatic applyReset();
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 4; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        #3;
        checks++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_asserted: ready=%b valid=%b rdata=%h err=%b, expected 0 0 00000000 0",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 || rsp_err[d] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle[%0d]: ready=%b valid=%b rdata=%h err=%b, expected 1 0 00000000 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            end
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic e;
        transact(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e);
        checks++;
        if (lat !== 2 || rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_10: lat=%0d rdata=%h err=%b, expected 2 00000000 0", lat, rd, e);
        end
        transact(0, 1'b0, 32'h10, 32'h0, lat, rd, e);
        checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_10: lat=%0d rdata=%h err=%b, expected 2 deadbeef 0", lat, rd, e);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e;
        logic [31:0] bad_addr [4];
        logic        bad_wr   [4];
        bad_addr[0] = 32'h12;        bad_wr[0] = 1'b0;
        bad_addr[1] = 32'h200;       bad_wr[1] = 1'b0;
        bad_addr[2] = 32'h200;       bad_wr[2] = 1'b1;
        bad_addr[3] = 32'h8000_0000; bad_wr[3] = 1'b0;
        transact(0, 1'b1, 32'h0, 32'hA5A50001, lat, rd, e);
        for (int i = 0; i < 4; i++) begin
            transact(0, bad_wr[i], bad_addr[i], 32'hFFFF_FFFF, lat, rd, e);
            checks++;
            if (lat !== 2 || rd !== 32'h0 || e !== 1'b1) begin
                errors++;
                $display("[TB] FAIL err_access[%0d] addr=%h: lat=%0d rdata=%h err=%b, expected 2 00000000 1",
                         i, bad_addr[i], lat, rd, e);
            end
        end
        transact(0, 1'b0, 32'h0, 32'h0, lat, rd, e);
        checks++;
        if (rd !== 32'hA5A50001 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_alias_word0: rdata=%h err=%b, expected a5a50001 0", rd, e);
        end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        int lat = 0;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        while (!req_ready[0] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        waited = 0;
        while (!rsp_valid[0] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        req_addr[0] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_cycle[%0d]: valid=%b rdata=%h err=%b ready=%b, expected 1 deadbeef 0 0",
                         i, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
            end
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_handshake: valid=%b ready=%b, expected 0 1", rsp_valid[0], req_ready[0]);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_after_handshake: ready=%b, expected 0", req_ready[0]);
        end
        while (!rsp_valid[0] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2 || rsp_rdata[0] !== 32'hA5A50001 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL queued_load: lat=%0d rdata=%h err=%b, expected 2 a5a50001 0",
                     lat, rsp_rdata[0], rsp_err[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [31:0] rd; logic e;
        int waited = 0;
        transact(1, 1'b1, 32'h20, 32'h0BADF00D, lat, rd, e);
        checks++;
        if (lat !== 4 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_store_lat4: lat=%0d err=%b, expected 4 0", lat, e);
        end
        // Park instance 0 in its response state so the async clear is observable.
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h10;
        while (!req_ready[0] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        waited = 0;
        while (!rsp_valid[0] && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL park_resp: valid=%b rdata=%h, expected 1 deadbeef", rsp_valid[0], rsp_rdata[0]);
        end
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_wdata[1] = 32'h12345678;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_resp: valid=%b rdata=%h err=%b ready=%b, expected 0 00000000 0 0",
                     rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
        end
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_wait: valid=%b ready=%b, expected 0 0", rsp_valid[1], req_ready[1]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        transact(1, 1'b0, 32'h20, 32'h0, lat, rd, e);
        checks++;
        if (lat !== 4 || rd !== 32'h0BADF00D || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abandoned_store: lat=%0d rdata=%h err=%b, expected 4 0badf00d 0", lat, rd, e);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int lat; logic [31:0] rd; logic e;
        logic [31:0] vals [3];
        vals[0] = 32'h1111_0000 + 32'(d);
        vals[1] = 32'h2222_0000 + 32'(d);
        vals[2] = 32'h3333_0000 + 32'(d);
        for (int i = 0; i < 3; i++) begin
            transact(d, 1'b1, 32'(i * 4), vals[i], lat, rd, e);
        end
        for (int i = 0; i < 3; i++) begin
            transact(d, 1'b0, 32'(i * 4), 32'h0, lat, rd, e);
            checks++;
            if (lat !== lat_of(d) || rd !== vals[i] || e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_lat%0d_load[%0d]: lat=%0d rdata=%h err=%b, expected %0d %h 0",
                         lat_of(d), i, lat, rd, e, lat_of(d), vals[i]);
            end
        end
    endtask

    initial begin
        $display("[TB] dmem_responder bench starting");
        test_reset();
        test_store_load();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back(2);
        test_back_to_back(3);
        applyReset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipelined CPU's MEM-stage data port. It receives load and store requests over a valid/ready request channel and stores words in an internal array. After a fixed, parameterised latency it returns read data or a store acknowledgement on a valid/ready response channel. It replaces the zero-latency data memory so the pipeline can be exercised against a realistic multi-cycle memory.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 32, byte-address width
DEPTH_WORDS, 128, number of words stored; word index = req_addr_i[ADDR_W-1:2]
LATENCY, 2, cycles from request acceptance to first rsp_valid_o cycle; legal range 1..15

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept a request
req_write_i  in  1  1 = store, 0 = load
req_addr_i  in  ADDR_W  byte address
req_wdata_i  in  DATA_W  store data
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  requester accepts response
rsp_rdata_o  out  DATA_W  load data; 0 for stores and errors
rsp_err_o  out  1  misaligned or out-of-range access

Behaviour:
- Reset (rst_i=0, async): state=IDLE, req_ready_o=0 while reset is asserted, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter=0. Array contents are not reset.
- Reset mid-operation abandons the transaction. A store not yet committed is never written.
- FSM states are IDLE, WAIT, RESP. Only one transaction is outstanding at a time.
- IDLE: req_ready_o=1. On an edge with req_valid_i&req_ready_o, latch write/addr/wdata, set cnt=LATENCY-1, and go to WAIT.
- WAIT: req_ready_o=0. If cnt!=0, decrement. If cnt==0, commit the access on this edge and go to RESP.
- Commit: err = (addr[1:0]!=0) | (word index >= DEPTH_WORDS).
  - Store with !err: array[index] <= wdata.
  - Load with !err: capture array[index] into rsp_rdata_o.
  - Stores and errors drive rsp_rdata_o=0. rsp_err_o is registered to err.
- Latency: if the request is accepted at edge k, rsp_valid_o is high in the cycle following edge k+LATENCY.
- RESP: rsp_valid_o=1 and rsp_rdata_o/rsp_err_o are held stable until an edge with rsp_ready_i=1. On that edge go to IDLE and clear rsp_valid_o. req_ready_o=0 throughout RESP. A new request is accepted no earlier than the edge after the handshake.
- rsp_ready_i may be high before rsp_valid_o; this does not shorten latency.
- Changes to req_* while req_ready_o=0 are ignored.
- Load after store to the same word returns the new data, since commit is ordered.
- Address wrap: no aliasing. An index >= DEPTH_WORDS is an error, never modulo.
- req_* signals may be X while req_valid_i=0 with no effect on state.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2
  - LAT_MAX=15, counter width 4
  - an elaboration check that 1 <= LATENCY <= LAT_MAX
- One natural sub-module, dmem_array: synchronous word storage with one write port and one registered read port, enable-gated, no reset. The FSM, counter and error logic stay in dmem_responder.

Test Plan:
- Reset, then idle with rst_i=1 -> req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
- Store addr 0x10 data 0xDEADBEEF, then load addr 0x10, rsp_ready_i=1, LATENCY=2 -> store rsp_valid_o is high 2 edges after acceptance with rdata 0 and err 0; the load returns 0xDEADBEEF with err 0.
- Load addr 0x12 (misaligned) and load addr 4*DEPTH_WORDS=0x200 -> rsp_err_o=1 and rsp_rdata_o=0 for both. A store to 0x200 leaves array word 0 unchanged, so a load of 0x0 returns its prior value.
- Response backpressure: rsp_ready_i=0 for 5 cycles after rsp_valid_o rises -> rsp_valid_o, rsp_rdata_o and rsp_err_o are stable, req_ready_o=0, and a new req_valid_i is not accepted until the edge after the handshake.
- Store addr 0x20 data 0x12345678, with rst_i pulsed low in WAIT (LATENCY=4) -> outputs return to reset values asynchronously; a subsequent load of 0x20 returns the pre-reset value, not 0x12345678.
- LATENCY=1 and LATENCY=15 builds, back-to-back loads of 0x0, 0x4, 0x8 with rsp_ready_i=1 -> responses arrive in order, each exactly LATENCY edges after its acceptance.
